// File: rtl/branch_ctrl_unit.sv
`default_nettype none
// ============================================================================
// Module   : branch_ctrl_unit
// Purpose  : Flag register and program-counter sequencer. Latches the ALU
//            flag word, evaluates a selected (optionally inverted) flag bit,
//            and steps the PC through NEXT / JCC / CALL / RET. A LIFO return
//            stack is kept in registers. On stack overflow or underflow the
//            unit enters a sticky FAULT state that only rst can clear.
// Ports    : clk, rst          - clock, synchronous active-high reset
//            FLG, flg_we       - ALU flag word and its load enable
//            step, br_op       - execute strobe and operation
//            cond_sel/cond_inv - flag bit select and inversion for JCC/CALL
//            target            - jump/call destination
//            PC, flags_q       - registered program counter and flags
//            taken             - 1-cycle pulse after a redirecting step
//            depth             - return-stack occupancy
//            fault, stk_ovf, stk_unf - sticky fault indications
// Revision : 1.0 - initial release
// ============================================================================
module branch_ctrl_unit #(
  parameter int               PC_W        = 8,
  parameter int               STACK_DEPTH = 4,
  parameter logic [PC_W-1:0]  RESET_PC    = '0
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [7:0]                           FLG,
  input  logic                                 flg_we,
  input  logic                                 step,
  input  logic [1:0]                           br_op,
  input  logic [2:0]                           cond_sel,
  input  logic                                 cond_inv,
  input  logic [PC_W-1:0]                      target,
  output logic [PC_W-1:0]                      PC,
  output logic [7:0]                           flags_q,
  output logic                                 taken,
  output logic [$clog2(STACK_DEPTH+1)-1:0]     depth,
  output logic                                 fault,
  output logic                                 stk_ovf,
  output logic                                 stk_unf
);

  localparam int c_DW = $clog2(STACK_DEPTH+1);

  localparam logic [1:0] c_OP_NEXT = 2'b00;
  localparam logic [1:0] c_OP_JCC  = 2'b01;
  localparam logic [1:0] c_OP_CALL = 2'b10;
  localparam logic [1:0] c_OP_RET  = 2'b11;

  localparam logic [0:0] c_ST_RUN   = 1'b0;
  localparam logic [0:0] c_ST_FAULT = 1'b1;

  localparam logic [c_DW-1:0] c_FULL = c_DW'(STACK_DEPTH);

  logic [0:0]       r_state;
  logic [0:0]       w_state_nxt;
  logic [PC_W-1:0]  r_pc;
  logic [7:0]       r_flags;
  logic             r_taken;
  logic [c_DW-1:0]  r_depth;
  logic             r_ovf;
  logic             r_unf;
  logic [PC_W-1:0]  r_stack [STACK_DEPTH];

  logic             w_active;
  logic             w_cond;
  logic [PC_W-1:0]  w_pc_inc;
  logic [PC_W-1:0]  w_top;
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic             w_ovf_evt;
  logic             w_unf_evt;

  // Condition uses the flag register as it stood before this edge, so a
  // simultaneous flg_we only becomes visible to the next step.
  assign w_active  = step && (r_state == c_ST_RUN);
  assign w_cond    = r_flags[cond_sel] ^ cond_inv;
  assign w_pc_inc  = r_pc + 1'b1;
  assign w_full    = (r_depth == c_FULL);
  assign w_empty   = (r_depth == '0);
  assign w_push    = w_active && (br_op == c_OP_CALL) && w_cond && !w_full;
  assign w_pop     = w_active && (br_op == c_OP_RET) && !w_empty;
  assign w_ovf_evt = w_active && (br_op == c_OP_CALL) && w_cond && w_full;
  assign w_unf_evt = w_active && (br_op == c_OP_RET) && w_empty;

  // Top-of-stack lives at index depth-1.
  always_comb begin
    w_top = '0;
    for (int i = 0; i < STACK_DEPTH; i++) begin
      if (r_depth == c_DW'(i + 1)) w_top = r_stack[i];
    end
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= c_ST_RUN;
    else     r_state <= w_state_nxt;
  end

  // FSM: next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_RUN:   if (w_ovf_evt || w_unf_evt) w_state_nxt = c_ST_FAULT;
      c_ST_FAULT: w_state_nxt = c_ST_FAULT;
      default:    w_state_nxt = c_ST_FAULT;
    endcase
  end

  // FSM: outputs
  always_comb begin
    fault = (r_state == c_ST_FAULT);
  end

  // Datapath: PC, flags, depth, pulse and sticky flags
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc    <= RESET_PC;
      r_flags <= 8'h40;
      r_taken <= 1'b0;
      r_depth <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      r_taken <= 1'b0;
      if (flg_we) r_flags <= {2'b01, FLG[5:0]};
      if (w_active) begin
        case (br_op)
          c_OP_NEXT: r_pc <= w_pc_inc;
          c_OP_JCC: begin
            r_pc    <= w_cond ? target : w_pc_inc;
            r_taken <= w_cond;
          end
          c_OP_CALL: begin
            if (!w_cond) begin
              r_pc <= w_pc_inc;
            end else if (!w_full) begin
              r_pc    <= target;
              r_depth <= r_depth + 1'b1;
              r_taken <= 1'b1;
            end else begin
              r_ovf <= 1'b1;
            end
          end
          default: begin
            if (!w_empty) begin
              r_pc    <= w_top;
              r_depth <= r_depth - 1'b1;
              r_taken <= 1'b1;
            end else begin
              r_unf <= 1'b1;
            end
          end
        endcase
      end
    end
  end

  // Return stack storage; contents are don't-care above depth, so no reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < STACK_DEPTH; i++) begin
      if (w_push && (r_depth == c_DW'(i))) r_stack[i] <= w_pc_inc;
    end
  end

  assign PC      = r_pc;
  assign flags_q = r_flags;
  assign taken   = r_taken;
  assign depth   = r_depth;
  assign stk_ovf = r_ovf;
  assign stk_unf = r_unf;

endmodule
`default_nettype wire

// File: tb/tb_branch_ctrl_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_ctrl_unit
// Purpose  : Directed self-checking bench for branch_ctrl_unit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_branch_ctrl_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] FLG;
  logic       flg_we;
  logic       step;
  logic [1:0] br_op;
  logic [2:0] cond_sel;
  logic       cond_inv;
  logic [7:0] target;
  logic [7:0] PC;
  logic [7:0] flags_q;
  logic       taken;
  logic [2:0] depth;
  logic       fault;
  logic       stk_ovf;
  logic       stk_unf;

  int n_checks = 0;
  int n_fail   = 0;

  branch_ctrl_unit #(.PC_W(8), .STACK_DEPTH(4), .RESET_PC(8'h00)) dut (
    .clk(clk), .rst(rst), .FLG(FLG), .flg_we(flg_we), .step(step),
    .br_op(br_op), .cond_sel(cond_sel), .cond_inv(cond_inv), .target(target),
    .PC(PC), .flags_q(flags_q), .taken(taken), .depth(depth), .fault(fault),
    .stk_ovf(stk_ovf), .stk_unf(stk_unf)
  );

  always #5 clk = ~clk;

  // Drive one cycle of stimulus, then sample 1 time unit after the edge.
  task automatic cyc(input logic s, input logic [1:0] op, input logic [2:0] sel,
                     input logic inv, input logic [7:0] tgt);
    step = s; br_op = op; cond_sel = sel; cond_inv = inv; target = tgt;
    @(posedge clk); #1;
    step = 1'b0; flg_we = 1'b0; rst = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(1'b0, 2'b00, 3'd0, 1'b0, 8'h00);
  endtask

  task automatic test_reset();
    FLG = 8'h00; flg_we = 1'b0;
    do_reset();
    n_checks++; if (PC !== 8'h00) begin n_fail++; $display("FAIL reset_pc: got %h want 00", PC); end
    n_checks++; if (flags_q !== 8'h40) begin n_fail++; $display("FAIL reset_flags: got %h want 40", flags_q); end
    n_checks++; if (depth !== 3'd0) begin n_fail++; $display("FAIL reset_depth: got %0d want 0", depth); end
    n_checks++; if ({taken, fault, stk_ovf, stk_unf} !== 4'b0000) begin n_fail++; $display("FAIL reset_status: got %b want 0000", {taken, fault, stk_ovf, stk_unf}); end
  endtask

  task automatic test_wrap();
    cyc(1'b1, 2'b01, 3'd6, 1'b0, 8'hFF);
    n_checks++; if ({PC, taken} !== {8'hFF, 1'b1}) begin n_fail++; $display("FAIL wrap_jmp: got PC=%h taken=%b want FF 1", PC, taken); end
    cyc(1'b1, 2'b00, 3'd0, 1'b0, 8'h00);
    n_checks++; if ({PC, taken} !== {8'h00, 1'b0}) begin n_fail++; $display("FAIL wrap_next: got PC=%h taken=%b want 00 0", PC, taken); end
    cyc(1'b0, 2'b01, 3'd6, 1'b0, 8'h33);
    n_checks++; if ({PC, taken} !== {8'h00, 1'b0}) begin n_fail++; $display("FAIL idle_hold: got PC=%h taken=%b want 00 0", PC, taken); end
  endtask

  task automatic test_flag_race();
    FLG = 8'h08; flg_we = 1'b1;
    cyc(1'b1, 2'b01, 3'd3, 1'b0, 8'h20);
    n_checks++; if ({PC, taken} !== {8'h01, 1'b0}) begin n_fail++; $display("FAIL race_old_flags: got PC=%h taken=%b want 01 0", PC, taken); end
    n_checks++; if (flags_q !== 8'h48) begin n_fail++; $display("FAIL race_flag_load: got %h want 48", flags_q); end
    cyc(1'b1, 2'b01, 3'd3, 1'b0, 8'h20);
    n_checks++; if ({PC, taken} !== {8'h20, 1'b1}) begin n_fail++; $display("FAIL race_new_flags: got PC=%h taken=%b want 20 1", PC, taken); end
    cyc(1'b1, 2'b01, 3'd3, 1'b1, 8'h30);
    n_checks++; if ({PC, taken} !== {8'h21, 1'b0}) begin n_fail++; $display("FAIL jcc_inv: got PC=%h taken=%b want 21 0", PC, taken); end
    FLG = 8'hBF; flg_we = 1'b1;
    cyc(1'b0, 2'b00, 3'd0, 1'b0, 8'h00);
    n_checks++; if (flags_q !== 8'h7F) begin n_fail++; $display("FAIL flag_force: got %h want 7F", flags_q); end
  endtask

  task automatic test_nesting();
    cyc(1'b1, 2'b01, 3'd6, 1'b0, 8'h10);
    cyc(1'b1, 2'b10, 3'd6, 1'b0, 8'h40);
    n_checks++; if ({PC, depth, taken} !== {8'h40, 3'd1, 1'b1}) begin n_fail++; $display("FAIL call1: got PC=%h depth=%0d taken=%b want 40 1 1", PC, depth, taken); end
    cyc(1'b1, 2'b10, 3'd6, 1'b0, 8'h80);
    n_checks++; if ({PC, depth, taken} !== {8'h80, 3'd2, 1'b1}) begin n_fail++; $display("FAIL call2: got PC=%h depth=%0d taken=%b want 80 2 1", PC, depth, taken); end
    cyc(1'b1, 2'b11, 3'd7, 1'b0, 8'h00);
    n_checks++; if ({PC, depth, taken} !== {8'h41, 3'd1, 1'b1}) begin n_fail++; $display("FAIL ret1: got PC=%h depth=%0d taken=%b want 41 1 1", PC, depth, taken); end
    cyc(1'b1, 2'b11, 3'd7, 1'b0, 8'h00);
    n_checks++; if ({PC, depth, taken} !== {8'h11, 3'd0, 1'b1}) begin n_fail++; $display("FAIL ret2: got PC=%h depth=%0d taken=%b want 11 0 1", PC, depth, taken); end
    cyc(1'b1, 2'b10, 3'd7, 1'b0, 8'h90);
    n_checks++; if ({PC, depth, taken} !== {8'h12, 3'd0, 1'b0}) begin n_fail++; $display("FAIL call_not_taken: got PC=%h depth=%0d taken=%b want 12 0 0", PC, depth, taken); end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 4; i++) cyc(1'b1, 2'b10, 3'd6, 1'b0, 8'h50 + 8'(i));
    n_checks++; if ({PC, depth, fault} !== {8'h53, 3'd4, 1'b0}) begin n_fail++; $display("FAIL ovf_fill: got PC=%h depth=%0d fault=%b want 53 4 0", PC, depth, fault); end
    cyc(1'b1, 2'b10, 3'd6, 1'b0, 8'h99);
    n_checks++; if ({PC, depth, taken} !== {8'h53, 3'd4, 1'b0}) begin n_fail++; $display("FAIL ovf_hold: got PC=%h depth=%0d taken=%b want 53 4 0", PC, depth, taken); end
    n_checks++; if ({fault, stk_ovf, stk_unf} !== 3'b110) begin n_fail++; $display("FAIL ovf_flags: got %b want 110", {fault, stk_ovf, stk_unf}); end
    FLG = 8'h08; flg_we = 1'b1;
    cyc(1'b1, 2'b11, 3'd0, 1'b0, 8'h00);
    n_checks++; if ({PC, depth, taken, fault} !== {8'h53, 3'd4, 1'b0, 1'b1}) begin n_fail++; $display("FAIL fault_ignore: got PC=%h depth=%0d taken=%b fault=%b want 53 4 0 1", PC, depth, taken, fault); end
    n_checks++; if (flags_q !== 8'h48) begin n_fail++; $display("FAIL fault_flg_we: got %h want 48", flags_q); end
    do_reset();
    n_checks++; if ({PC, depth, fault, stk_ovf} !== {8'h00, 3'd0, 1'b0, 1'b0}) begin n_fail++; $display("FAIL ovf_clear: got PC=%h depth=%0d fault=%b ovf=%b want 00 0 0 0", PC, depth, fault, stk_ovf); end
  endtask

  task automatic test_underflow();
    cyc(1'b1, 2'b00, 3'd0, 1'b0, 8'h00);
    cyc(1'b1, 2'b11, 3'd0, 1'b0, 8'h00);
    n_checks++; if ({PC, taken, depth} !== {8'h01, 1'b0, 3'd0}) begin n_fail++; $display("FAIL unf_hold: got PC=%h taken=%b depth=%0d want 01 0 0", PC, taken, depth); end
    n_checks++; if ({fault, stk_ovf, stk_unf} !== 3'b101) begin n_fail++; $display("FAIL unf_flags: got %b want 101", {fault, stk_ovf, stk_unf}); end
    do_reset();
    cyc(1'b1, 2'b01, 3'd7, 1'b0, 8'h77);
    n_checks++; if ({PC, taken} !== {8'h01, 1'b0}) begin n_fail++; $display("FAIL cont_never: got PC=%h taken=%b want 01 0", PC, taken); end
    cyc(1'b1, 2'b01, 3'd7, 1'b1, 8'h77);
    n_checks++; if ({PC, taken} !== {8'h77, 1'b1}) begin n_fail++; $display("FAIL cont_inv: got PC=%h taken=%b want 77 1", PC, taken); end
  endtask

  initial begin
    rst = 1'b1; FLG = 8'h00; flg_we = 1'b0; step = 1'b0; br_op = 2'b00;
    cond_sel = 3'd0; cond_inv = 1'b0; target = 8'h00;
    test_reset();
    test_wrap();
    test_flag_race();
    test_nesting();
    test_overflow();
    test_underflow();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
